// File: rtl/operand_forward_stage.sv
// -----------------------------------------------------------------------------
// operand_forward_stage
//
// ID/EX pipeline register with operand forwarding and load-use interlock.
//
// The stage captures the decoded instruction (valid, rd, write enable, load
// flag, source addresses and register-file read data) into the EX register.
// Operands presented to EX are then bypassed from the MEM or WB stage when
// those stages are about to write the register the EX instruction reads.
// Forwarding is combinational from the EX-held source addresses. A load in EX
// whose destination is read by the instruction in ID stalls ID for LOAD_LAT
// cycles. During that time bubbles are inserted into EX.
//
// Parameters
//   XLEN     operand data width
//   NUM_SRC  source operands per instruction (1..3)
//   REG_AW   register address width
//   LOAD_LAT stall cycles per load-use hazard (1..3)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_valid            ID holds a valid instruction
//   id_rs_addr          source addresses, source i in slice i
//   id_rs_data          register-file read data, source i in slice i
//   id_rd/id_wen        destination register and its write enable
//   id_is_load          instruction is a load
//   id_ready            ID may advance this cycle
//   flush               kill the instruction entering EX
//   ex_valid/ex_rd/ex_wen/ex_is_load   registered EX control fields
//   ex_op               forwarded operands, source i in slice i
//   fwd_sel             per-source select: 00 register, 01 WB, 10 MEM
//   mem_valid/mem_wen/mem_rd/mem_result   MEM stage write port
//   wb_valid/wb_wen/wb_rd/wb_data         WB stage write port
// -----------------------------------------------------------------------------
module operand_forward_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC*XLEN-1:0]   id_rs_data,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  output logic                      id_ready,
  input  logic                      flush,
  output logic                      ex_valid,
  output logic [REG_AW-1:0]         ex_rd,
  output logic                      ex_wen,
  output logic                      ex_is_load,
  output logic [NUM_SRC*XLEN-1:0]   ex_op,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  input  logic                      mem_valid,
  input  logic                      mem_wen,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [XLEN-1:0]           mem_result,
  input  logic                      wb_valid,
  input  logic                      wb_wen,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]           wb_data
);

  // Value loaded into the stall counter when a hazard is first seen. The
  // hazard cycle itself is one stall cycle, so the counter only covers the
  // remaining LOAD_LAT-1 cycles.
  localparam logic [1:0] STALL_LOAD = 2'(LOAD_LAT - 1);

  // ID/EX register
  logic                      r_ex_valid;
  logic [REG_AW-1:0]         r_ex_rd;
  logic                      r_ex_wen;
  logic                      r_ex_is_load;
  logic [NUM_SRC*REG_AW-1:0] r_ex_rs_addr;
  logic [NUM_SRC*XLEN-1:0]   r_ex_opnd;
  logic [1:0]                r_stall_cnt;

  // Combinational helpers
  logic [NUM_SRC-1:0]        w_rs_match_ex;
  logic [NUM_SRC*XLEN-1:0]   w_capture_data;
  logic                      w_ex_load_writes;
  logic                      w_hz;
  logic                      w_id_ready;
  logic                      w_mem_writes;
  logic                      w_wb_writes;

  // Qualified write ports; register 0 never counts as a write.
  assign w_mem_writes = mem_valid & mem_wen & (mem_rd != '0);
  assign w_wb_writes  = wb_valid  & wb_wen  & (wb_rd  != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_id_rs;
      logic [REG_AW-1:0] w_ex_rs;
      logic              w_wt_hit;
      logic              w_mem_hit;
      logic              w_wb_hit;

      assign w_id_rs = id_rs_addr[gi*REG_AW +: REG_AW];
      assign w_ex_rs = r_ex_rs_addr[gi*REG_AW +: REG_AW];

      // Hazard comparison against the EX destination. The x0 exclusion is
      // applied once on ex_rd in the hazard term.
      assign w_rs_match_ex[gi] = (w_id_rs == r_ex_rd);

      // Write-through: the register file is written by WB on the same edge
      // that EX captures, so its read data is stale; take wb_data instead.
      assign w_wt_hit = w_wb_writes & (wb_rd == w_id_rs);
      assign w_capture_data[gi*XLEN +: XLEN] =
        w_wt_hit ? wb_data : id_rs_data[gi*XLEN +: XLEN];

      // Bypass selection, MEM is younger than WB so it wins a double hit.
      assign w_mem_hit = w_mem_writes & (mem_rd == w_ex_rs);
      assign w_wb_hit  = w_wb_writes  & (wb_rd  == w_ex_rs);

      assign fwd_sel[2*gi +: 2] = w_mem_hit ? 2'b10 :
                                  w_wb_hit  ? 2'b01 : 2'b00;

      assign ex_op[gi*XLEN +: XLEN] = w_mem_hit ? mem_result :
                                      w_wb_hit  ? wb_data    :
                                      r_ex_opnd[gi*XLEN +: XLEN];
    end
  endgenerate

  // Load-use hazard: the load in EX produces its data too late to be
  // forwarded to the instruction now in ID.
  assign w_ex_load_writes = r_ex_valid & r_ex_is_load & r_ex_wen & (r_ex_rd != '0);
  assign w_hz             = id_valid & w_ex_load_writes & (|w_rs_match_ex);
  assign w_id_ready       = ~(w_hz | (r_stall_cnt != 2'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd      <= '0;
      r_ex_wen     <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_rs_addr <= '0;
      r_ex_opnd    <= '0;
      r_stall_cnt  <= 2'd0;
    end else begin
      // Stall counter; flush abandons any stall in progress.
      if (flush) begin
        r_stall_cnt <= 2'd0;
      end else if (r_stall_cnt != 2'd0) begin
        r_stall_cnt <= r_stall_cnt - 2'd1;
      end else if (w_hz) begin
        r_stall_cnt <= STALL_LOAD;
      end

      // EX register: flush or stall inserts a bubble. The other fields of a
      // bubble are never looked at, so they simply hold.
      if (flush || !w_id_ready) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid   <= id_valid;
        r_ex_rd      <= id_rd;
        r_ex_wen     <= id_wen;
        r_ex_is_load <= id_is_load;
        r_ex_rs_addr <= id_rs_addr;
        r_ex_opnd    <= w_capture_data;
      end
    end
  end

  assign id_ready   = w_id_ready;
  assign ex_valid   = r_ex_valid;
  assign ex_rd      = r_ex_rd;
  assign ex_wen     = r_ex_wen;
  assign ex_is_load = r_ex_is_load;

endmodule

// File: tb/tb_operand_forward_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_forward_stage
//
// Two instances share every input: u_dut_a uses LOAD_LAT=2, u_dut_b uses
// LOAD_LAT=3. Each instruction issued to u_dut_a pushes its expected EX
// record into a queue. A monitor pops and compares whenever u_dut_a shows
// ex_valid. Interlock, flush and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_operand_forward_stage;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic               id_valid;
  logic [NS*AW-1:0]   id_rs_addr;
  logic [NS*XLEN-1:0] id_rs_data;
  logic [AW-1:0]      id_rd;
  logic               id_wen;
  logic               id_is_load;
  logic               flush;
  logic               mem_valid, mem_wen;
  logic [AW-1:0]      mem_rd;
  logic [XLEN-1:0]    mem_result;
  logic               wb_valid, wb_wen;
  logic [AW-1:0]      wb_rd;
  logic [XLEN-1:0]    wb_data;

  logic               id_ready_a, ex_valid_a, ex_wen_a, ex_is_load_a;
  logic [AW-1:0]      ex_rd_a;
  logic [NS*XLEN-1:0] ex_op_a;
  logic [2*NS-1:0]    fwd_sel_a;

  logic               id_ready_b, ex_valid_b, ex_wen_b, ex_is_load_b;
  logic [AW-1:0]      ex_rd_b;
  logic [NS*XLEN-1:0] ex_op_b;
  logic [2*NS-1:0]    fwd_sel_b;

  operand_forward_stage #(.XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_data(id_rs_data), .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_ready(id_ready_a), .flush(flush), .ex_valid(ex_valid_a), .ex_rd(ex_rd_a),
    .ex_wen(ex_wen_a), .ex_is_load(ex_is_load_a), .ex_op(ex_op_a), .fwd_sel(fwd_sel_a),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  operand_forward_stage #(.XLEN(XLEN), .NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_data(id_rs_data), .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_ready(id_ready_b), .flush(flush), .ex_valid(ex_valid_b), .ex_rd(ex_rd_b),
    .ex_wen(ex_wen_b), .ex_is_load(ex_is_load_b), .ex_op(ex_op_b), .fwd_sel(fwd_sel_b),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EX record: {rd, wen, is_load, fwd_sel, ex_op}
  typedef struct packed {
    logic [AW-1:0]      rd;
    logic               wen;
    logic               ld;
    logic [2*NS-1:0]    sel;
    logic [NS*XLEN-1:0] op;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                        input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                        input logic [AW-1:0] rd, input logic wen, input logic ld);
    id_valid   = v;
    id_rs_addr = {rs1, rs0};
    id_rs_data = {d1, d0};
    id_rd      = rd;
    id_wen     = wen;
    id_is_load = ld;
  endtask

  task automatic set_mem(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] res);
    mem_valid  = v;
    mem_wen    = v;
    mem_rd     = rd;
    mem_result = res;
  endtask

  task automatic set_wb(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_valid = v;
    wb_wen   = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic idle_all();
    set_id(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    set_mem(1'b0, '0, '0);
    set_wb(1'b0, '0, '0);
    flush = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic wen, input logic ld,
                      input logic [2*NS-1:0] sel, input logic [XLEN-1:0] op1,
                      input logic [XLEN-1:0] op0);
    exp_t e;
    e.rd  = rd;
    e.wen = wen;
    e.ld  = ld;
    e.sel = sel;
    e.op  = {op1, op0};
    sb_q.push_back(e);
  endtask

  // Monitor: every valid EX cycle of u_dut_a consumes one expected record.
  always @(negedge clk) begin
    if (!rst && ex_valid_a) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ex_unexpected: got valid EX rd=%0d expected no instruction (t=%0t)",
                 ex_rd_a, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("EX rd=%0d wen=%0b ld=%0b sel=%b op=%h", ex_rd_a, ex_wen_a,
                 ex_is_load_a, fwd_sel_a, ex_op_a);
        check("ex_capture", 128'({ex_rd_a, ex_wen_a, ex_is_load_a, fwd_sel_a, ex_op_a}),
              128'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_all();

    // Reset state before any clock edge (asynchronous reset)
    #2;
    check("rst_ex_valid", 128'(ex_valid_a), 128'(0));
    check("rst_ex_fields", 128'({ex_rd_a, ex_wen_a, ex_is_load_a}), 128'(0));
    check("rst_ex_op", 128'(ex_op_a), 128'(0));
    check("rst_fwd_sel", 128'(fwd_sel_a), 128'(0));
    check("rst_id_ready", 128'(id_ready_a), 128'(1));
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back ALU: x3 in MEM forwards to src0 (first edge after reset)
    set_id(1'b1, 5'd3, 5'd4, 32'h111, 32'h222, 5'd8, 1'b1, 1'b0);
    push(5'd8, 1'b1, 1'b0, 4'b0010, 32'h222, 32'h10);
    tick();
    idle_all();
    set_mem(1'b1, 5'd3, 32'h10);
    tick();

    // Double hit on x5: MEM wins over WB
    idle_all();
    set_id(1'b1, 5'd5, 5'd5, 32'h1, 32'h2, 5'd6, 1'b1, 1'b0);
    push(5'd6, 1'b1, 1'b0, 4'b1010, 32'hAA, 32'hAA);
    tick();
    idle_all();
    set_mem(1'b1, 5'd5, 32'hAA);
    set_wb(1'b1, 5'd5, 32'hBB);
    tick();

    // WB-only forward on src1; MEM writes an unrelated register
    idle_all();
    set_id(1'b1, 5'd6, 5'd2, 32'h33, 32'h44, 5'd12, 1'b0, 1'b0);
    push(5'd12, 1'b0, 1'b0, 4'b0100, 32'h55, 32'h33);
    tick();
    idle_all();
    set_mem(1'b1, 5'd7, 32'h99);
    set_wb(1'b1, 5'd2, 32'h55);
    tick();

    // x0: load to x0 in EX, writers target x0; no forward, no stall,
    // no write-through of x0
    idle_all();
    set_id(1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    push(5'd0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h0);
    tick();
    set_id(1'b1, 5'd0, 5'd1, 32'h0, 32'h77, 5'd9, 1'b1, 1'b0);
    set_mem(1'b1, 5'd0, 32'hDEAD);
    set_wb(1'b1, 5'd0, 32'hBEEF);
    push(5'd9, 1'b1, 1'b0, 4'b0000, 32'h77, 32'h0);
    #1;
    check("x0_no_stall", 128'(id_ready_a), 128'(1));
    tick();
    idle_all();
    tick();

    // Write-through: WB writes x9 on the capture edge
    set_id(1'b1, 5'd9, 5'd10, 32'h0, 32'h5, 5'd13, 1'b1, 1'b0);
    set_wb(1'b1, 5'd9, 32'h1234);
    push(5'd13, 1'b1, 1'b0, 4'b0000, 32'h5, 32'h1234);
    tick();
    idle_all();
    tick();

    // Load-use, LOAD_LAT=2: lw x7 then a reader of x7
    set_id(1'b1, 5'd1, 5'd2, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1);
    push(5'd7, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h100);
    tick();
    set_id(1'b1, 5'd7, 5'd3, 32'h700, 32'h300, 5'd11, 1'b1, 1'b0);
    #1;
    check("lu_stall_cycle1", 128'(id_ready_a), 128'(0));
    tick();
    check("lu_stall_cycle2", 128'(id_ready_a), 128'(0));
    tick();
    check("lu_ready_after2", 128'(id_ready_a), 128'(1));
    set_wb(1'b1, 5'd7, 32'hCAFE);
    push(5'd11, 1'b1, 1'b0, 4'b0000, 32'h300, 32'hCAFE);
    tick();
    idle_all();
    tick();
    tick();

    // Clean start for the flush test
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Flush mid-stall, LOAD_LAT=3 (u_dut_b), after one stall cycle
    set_id(1'b1, 5'd1, 5'd0, 32'h42, 32'h0, 5'd7, 1'b1, 1'b1);
    push(5'd7, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h42);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0);
    #1;
    check("fl_stall_b", 128'(id_ready_b), 128'(0));
    tick();
    flush = 1'b1;
    #1;
    check("fl_midstall_b", 128'(id_ready_b), 128'(0));
    tick();
    idle_all();
    #1;
    check("fl_ready_b", 128'(id_ready_b), 128'(1));
    check("fl_ex_valid_b", 128'(ex_valid_b), 128'(0));
    check("fl_ex_valid_a", 128'(ex_valid_a), 128'(0));
    tick();

    // Reset asserted mid-stall: outputs return to reset values without an edge
    set_id(1'b1, 5'd1, 5'd2, 32'h5, 32'h6, 5'd7, 1'b1, 1'b1);
    push(5'd7, 1'b1, 1'b1, 4'b0000, 32'h6, 32'h5);
    tick();
    set_id(1'b1, 5'd7, 5'd0, 32'h0, 32'h0, 5'd15, 1'b1, 1'b0);
    #1;
    check("rs_stall_b", 128'(id_ready_b), 128'(0));
    tick();
    rst = 1'b1;
    #1;
    check("rs_outs_b", 128'({ex_valid_b, ex_rd_b, ex_wen_b, ex_is_load_b, fwd_sel_b, id_ready_b}),
          128'(1));
    check("rs_op_b", 128'(ex_op_b), 128'(0));
    check("rs_outs_a", 128'({ex_valid_a, ex_rd_a, ex_wen_a, ex_is_load_a, fwd_sel_a, id_ready_a}),
          128'(1));
    check("rs_op_a", 128'(ex_op_a), 128'(0));
    idle_all();
    tick();
    rst = 1'b0;
    tick();
    tick();

    check("sb_drain", 128'(sb_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
